// File: rtl/led_cmd_decoder.sv
// led_cmd_decoder: parses SPI byte frames (command, operand, value)
// and updates the per-LED brightness and enable registers.
// Ports: sysclk, rst (async, active-high); i_cs_n, i_rx_valid, i_rx_byte
// from the SPI slave; o_d (N_LEDS x BRIGHTNESS_WIDTH brightness),
// o_enb (per-LED enable), o_tx_byte (readback), o_frame_done (pulse),
// o_err (sticky until next frame start).
// Macro LED_READBACK_EN enables the READ (0x03) command and readback mux.
// BRIGHTNESS_WIDTH normally comes from params.vh; defaults to 8 here.
`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 8
`endif

module led_cmd_decoder #(
    parameter int N_LEDS = 4
) (
    input  logic                               sysclk,
    input  logic                               rst,
    input  logic                               i_cs_n,
    input  logic                               i_rx_valid,
    input  logic [7:0]                         i_rx_byte,
    output logic [N_LEDS*`BRIGHTNESS_WIDTH-1:0] o_d,
    output logic [N_LEDS-1:0]                  o_enb,
    output logic [7:0]                         o_tx_byte,
    output logic                               o_frame_done,
    output logic                               o_err
);
    localparam int BW = `BRIGHTNESS_WIDTH;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_ENABLE = 8'h02;
`ifdef LED_READBACK_EN
    localparam logic [7:0] CMD_READ   = 8'h03;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_OPND,
        S_DATA,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [7:0]           cmd, cmd_n;
    logic [2:0]           idx, idx_n;
    logic [N_LEDS*BW-1:0] d_n;
    logic [N_LEDS-1:0]    enb_n;
    logic                 done_n;
    logic                 err_n;
    logic                 cmd_ok;
    logic                 idx_ok;

`ifdef LED_READBACK_EN
    logic [7:0] tx_q, tx_n;
    assign o_tx_byte = tx_q;
`else
    assign o_tx_byte = 8'h00;
`endif

    // Full byte is compared so indices like 0x40 are rejected too.
    assign idx_ok = (i_rx_byte < 8'(N_LEDS));

    always_comb begin
        cmd_ok = (i_rx_byte == CMD_WRITE) || (i_rx_byte == CMD_ENABLE);
`ifdef LED_READBACK_EN
        if (i_rx_byte == CMD_READ) begin
            cmd_ok = 1'b1;
        end
`endif
    end

    always_comb begin
        state_n = state;
        cmd_n   = cmd;
        idx_n   = idx;
        d_n     = o_d;
        enb_n   = o_enb;
        done_n  = 1'b0;
        err_n   = o_err;
`ifdef LED_READBACK_EN
        tx_n    = tx_q;
`endif
        // Chip-select high overrides everything, including a byte
        // arriving in the same cycle.
        if (i_cs_n) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    err_n   = 1'b0;
                    state_n = S_CMD;
                end
                S_CMD: begin
                    if (i_rx_valid) begin
                        cmd_n = i_rx_byte;
                        if (cmd_ok) begin
                            state_n = S_OPND;
                        end else begin
                            err_n   = 1'b1;
                            state_n = S_DONE;
                        end
                    end
                end
                S_OPND: begin
                    if (i_rx_valid) begin
                        state_n = S_DONE;
                        if (cmd == CMD_ENABLE) begin
                            enb_n  = i_rx_byte[N_LEDS-1:0];
                            done_n = 1'b1;
                        end else if (!idx_ok) begin
                            err_n = 1'b1;
                        end else if (cmd == CMD_WRITE) begin
                            idx_n   = i_rx_byte[2:0];
                            state_n = S_DATA;
                        end
`ifdef LED_READBACK_EN
                        else begin
                            tx_n   = 8'(o_d[i_rx_byte[2:0]*BW +: BW]);
                            done_n = 1'b1;
                        end
`endif
                    end
                end
                S_DATA: begin
                    if (i_rx_valid) begin
                        d_n[idx*BW +: BW] = i_rx_byte[BW-1:0];
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end
                end
                S_DONE: begin
                    state_n = S_DONE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cmd          <= 8'h00;
            idx          <= 3'd0;
            o_d          <= '0;
            o_enb        <= '0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state        <= state_n;
            cmd          <= cmd_n;
            idx          <= idx_n;
            o_d          <= d_n;
            o_enb        <= enb_n;
            o_frame_done <= done_n;
            o_err        <= err_n;
        end
    end

`ifdef LED_READBACK_EN
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            tx_q <= 8'h00;
        end else begin
            tx_q <= tx_n;
        end
    end
`endif

endmodule

// File: tb/tb_led_cmd_decoder.sv
// tb_led_cmd_decoder: directed frames against led_cmd_decoder
// (N_LEDS = 4), honouring LED_READBACK_EN when defined.
`timescale 1ns/1ps
`ifndef BRIGHTNESS_WIDTH
`define BRIGHTNESS_WIDTH 8
`endif

module tb_led_cmd_decoder;
    localparam int N  = 4;
    localparam int BW = `BRIGHTNESS_WIDTH;

    logic          sysclk = 1'b0;
    logic          rst = 1'b0;
    logic          cs_n = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic [N*BW-1:0] d;
    logic [N-1:0]  enb;
    logic [7:0]    tx;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int dc0;

    logic [BW-1:0] m [N];

    led_cmd_decoder #(.N_LEDS(N)) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .i_cs_n      (cs_n),
        .i_rx_valid  (rx_valid),
        .i_rx_byte   (rx_byte),
        .o_d         (d),
        .o_enb       (enb),
        .o_tx_byte   (tx),
        .o_frame_done(done),
        .o_err       (err)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) if (done === 1'b1) done_cnt++;

    function automatic logic [BW-1:0] tr(input logic [7:0] v);
        return v[BW-1:0];
    endfunction

    function automatic logic [N*BW-1:0] exp_d();
        logic [N*BW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*BW +: BW] = m[k];
        return r;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++) m[k] = '0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge sysclk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge sysclk);
        checks++;
        if (d !== '0) begin
            errors++; $display("FAIL reset_d got %h expected 0", d);
        end
        checks++;
        if ({enb, tx, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_ctl got enb=%b tx=%h done=%b err=%b expected 0",
                     enb, tx, done, err);
        end
        rst = 1'b0;
        @(negedge sysclk);
    endtask

    task automatic test_write();
        dc0 = done_cnt;
        cs_low();
        send(8'h01);
        send(8'h02);
        send(8'h80);
        m[2] = tr(8'h80);
        checks++;
        if (d !== exp_d()) begin
            errors++; $display("FAIL write_d got %h expected %h", d, exp_d());
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL write_done got %b expected 1", done);
        end
        @(negedge sysclk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL write_done_width got %b expected 0", done);
        end
        cs_high();
        checks++;
        if (done_cnt - dc0 !== 1) begin
            errors++; $display("FAIL write_pulses got %0d expected 1", done_cnt - dc0);
        end
    endtask

    task automatic test_enable_bad_index();
        dc0 = done_cnt;
        cs_low();
        send(8'h02);
        send(8'h0B);
        checks++;
        if (enb !== 4'b1011 || done !== 1'b1) begin
            errors++;
            $display("FAIL enable got enb=%b done=%b expected 1011 1", enb, done);
        end
        cs_high();
        dc0 = done_cnt;
        cs_low();
        send(8'h01);
        send(8'h05);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL badidx_err got %b expected 1", err);
        end
        send(8'h10);
        cs_high();
        checks++;
        if (d !== exp_d() || done_cnt - dc0 !== 1 - 1) begin
            errors++;
            $display("FAIL badidx_nochange got d=%h pulses=%0d expected %h 0",
                     d, done_cnt - dc0, exp_d());
        end
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_sticky got %b expected 1", err);
        end
        cs_low();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_clear got %b expected 0", err);
        end
        cs_high();
    endtask

    task automatic test_abort();
        dc0 = done_cnt;
        cs_low();
        send(8'h01);
        send(8'h01);
        cs_high();
        checks++;
        if (d !== exp_d() || err !== 1'b0 || done_cnt != dc0) begin
            errors++;
            $display("FAIL abort got d=%h err=%b pulses=%0d expected %h 0 0",
                     d, err, done_cnt - dc0, exp_d());
        end
        // Byte arriving in the same cycle chip-select rises is dropped.
        cs_low();
        send(8'h02);
        cs_n     = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'h00;
        @(negedge sysclk);
        rx_valid = 1'b0;
        @(negedge sysclk);
        checks++;
        if (enb !== 4'b1011 || done_cnt != dc0) begin
            errors++;
            $display("FAIL cs_wins got enb=%b pulses=%0d expected 1011 0",
                     enb, done_cnt - dc0);
        end
        cs_low();
        send(8'h01);
        send(8'h01);
        send(8'h33);
        m[1] = tr(8'h33);
        cs_high();
        checks++;
        if (d !== exp_d() || done_cnt - dc0 !== 1) begin
            errors++;
            $display("FAIL after_abort got d=%h pulses=%0d expected %h 1",
                     d, done_cnt - dc0, exp_d());
        end
    endtask

    task automatic test_read();
        logic [7:0] e;
        cs_low();
        send(8'h01);
        send(8'h03);
        send(8'hA5);
        m[3] = tr(8'hA5);
        cs_high();
        dc0 = done_cnt;
        e = 8'h00;
        e[BW-1:0] = m[3];
        cs_low();
        send(8'h03);
        send(8'h03);
`ifdef LED_READBACK_EN
        checks++;
        if (tx !== e || err !== 1'b0) begin
            errors++; $display("FAIL read got tx=%h err=%b expected %h 0", tx, err, e);
        end
        cs_high();
        checks++;
        if (done_cnt - dc0 !== 1) begin
            errors++; $display("FAIL read_pulses got %0d expected 1", done_cnt - dc0);
        end
        cs_low();
        send(8'h03);
        send(8'h06);
        checks++;
        if (err !== 1'b1 || tx !== e) begin
            errors++;
            $display("FAIL read_badidx got err=%b tx=%h expected 1 %h", err, tx, e);
        end
        cs_high();
`else
        checks++;
        if (err !== 1'b1 || tx !== 8'h00) begin
            errors++;
            $display("FAIL read_illegal got err=%b tx=%h expected 1 00", err, tx);
        end
        cs_high();
        checks++;
        if (done_cnt != dc0) begin
            errors++; $display("FAIL read_pulses got %0d expected 0", done_cnt - dc0);
        end
`endif
        checks++;
        if (d !== exp_d()) begin
            errors++; $display("FAIL read_d got %h expected %h", d, exp_d());
        end
    endtask

    task automatic test_back_to_back();
        cs_low();
        send(8'h07);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL illegal_cmd got %b expected 1", err);
        end
        cs_high();
        dc0 = done_cnt;
        cs_low();
        send(8'h02);
        send(8'h0F);
        send(8'hFF);
        send(8'hFF);
        checks++;
        if (enb !== 4'hF || err !== 1'b0) begin
            errors++;
            $display("FAIL trailing got enb=%h err=%b expected f 0", enb, err);
        end
        cs_high();
        checks++;
        if (done_cnt - dc0 !== 1) begin
            errors++; $display("FAIL trailing_pulses got %0d expected 1", done_cnt - dc0);
        end
    endtask

    task automatic test_reset_mid();
        cs_low();
        send(8'h01);
        send(8'h00);
        #2 rst = 1'b1;
        #1;
        clear_model();
        checks++;
        if (d !== '0 || enb !== '0 || tx !== 8'h00 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got d=%h enb=%b tx=%h done=%b err=%b expected 0",
                     d, enb, tx, done, err);
        end
        @(negedge sysclk);
        rst = 1'b0;
        cs_high();
        dc0 = done_cnt;
        cs_low();
        send(8'h01);
        send(8'h00);
        send(8'h5A);
        m[0] = tr(8'h5A);
        cs_high();
        checks++;
        if (d !== exp_d() || done_cnt - dc0 !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_rst got d=%h pulses=%0d err=%b expected %h 1 0",
                     d, done_cnt - dc0, err, exp_d());
        end
    endtask

    initial begin
        @(negedge sysclk);
        test_reset();
        test_write();
        test_enable_bad_index();
        test_abort();
        test_read();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
